// File: rtl/bus_arbiter_pkg.sv
// Shared types for the fetch/memory-stage bus arbiter.
package bus_arbiter_pkg;

  // Arbiter FSM state: idle, or which requester owns the external port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MEM   = 2'd2
  } state_e;

  // Grant decision produced by the priority logic.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_MEM   = 2'd2
  } sel_e;

  // Bits needed to hold a starvation count of 0..limit (never less than 1).
  function automatic int unsigned count_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response signals of the fetch port, the memory-stage port and the
// shared external memory port. The slave modport is the arbiter's view.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  fetch_request;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_ready;

  logic                  mem_request;
  logic                  mem_write;
  logic [STRB_WIDTH-1:0] mem_strobe;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_ready;

  logic                  ext_valid;
  logic                  ext_write;
  logic [STRB_WIDTH-1:0] ext_strobe;
  logic [ADDR_WIDTH-1:0] ext_address;
  logic [DATA_WIDTH-1:0] ext_write_data;
  logic [DATA_WIDTH-1:0] ext_read_data;
  logic                  ext_ready;

  modport slave (
    input  fetch_request, fetch_address,
    output fetch_data, fetch_ready,
    input  mem_request, mem_write, mem_strobe, mem_address, mem_write_data,
    output mem_read_data, mem_ready,
    output ext_valid, ext_write, ext_strobe, ext_address, ext_write_data,
    input  ext_read_data, ext_ready
  );

  modport master (
    output fetch_request, fetch_address,
    input  fetch_data, fetch_ready,
    output mem_request, mem_write, mem_strobe, mem_address, mem_write_data,
    input  mem_read_data, mem_ready,
    input  ext_valid, ext_write, ext_strobe, ext_address, ext_write_data,
    output ext_read_data, ext_ready
  );

endinterface

// File: rtl/bus_arbiter_priority.sv
// Combinational grant decision: memory stage first, unless fetch has waited
// through STARVE_LIMIT consecutive memory grants.
module bus_arbiter_priority
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned COUNT_WIDTH  = 3
) (
  input  logic                   enable,
  input  logic                   fetch_request,
  input  logic                   mem_request,
  input  logic [COUNT_WIDTH-1:0] starve_count,
  output sel_e                   grant
);

  logic starved;

  assign starved = fetch_request && (starve_count == COUNT_WIDTH'(STARVE_LIMIT));

  // Pick the requester to own the next external transaction.
  always_comb begin
    grant = SEL_NONE;
    if (enable) begin
      if (mem_request && !starved) begin
        grant = SEL_MEM;
      end else if (fetch_request) begin
        grant = SEL_FETCH;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external memory port between instruction fetch and the memory
// stage, one transaction at a time, and produces the stall levels for both.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned COUNT_WIDTH = count_width(STARVE_LIMIT);
  localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);

  state_e                  state;
  sel_e                    grant;
  logic                    ext_valid;
  logic                    ext_write;
  logic [STRB_WIDTH-1:0]   ext_strobe;
  logic [ADDR_WIDTH-1:0]   ext_address;
  logic [DATA_WIDTH-1:0]   ext_write_data;
  logic [DATA_WIDTH-1:0]   fetch_data;
  logic [DATA_WIDTH-1:0]   mem_read_data;
  logic                    fetch_done;
  logic                    mem_done;
  logic [COUNT_WIDTH-1:0]  starve_count;
  logic                    arb_enable;
  logic                    fetch_current;

  // No new grant while a done flag is up, so the finishing requester's
  // pipeline stage advances before it can be granted again.
  assign arb_enable = (state == IDLE) && !fetch_done && !mem_done;

  // A fetch result is only delivered if fetch still wants the same address.
  assign fetch_current = bus.fetch_request && (ext_address == bus.fetch_address);

  bus_arbiter_priority #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_priority (
    .enable        (arb_enable),
    .fetch_request (bus.fetch_request),
    .mem_request   (bus.mem_request),
    .starve_count  (starve_count),
    .grant         (grant)
  );

  // FSM, external request registers, read-data capture and starvation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ext_valid      <= 1'b0;
      ext_write      <= 1'b0;
      ext_strobe     <= '0;
      ext_address    <= '0;
      ext_write_data <= '0;
      fetch_data     <= '0;
      mem_read_data  <= '0;
      fetch_done     <= 1'b0;
      mem_done       <= 1'b0;
      starve_count   <= '0;
    end else begin
      fetch_done <= 1'b0;
      mem_done   <= 1'b0;
      if (!bus.fetch_request) begin
        starve_count <= '0;
      end
      case (state)
        IDLE: begin
          if (grant == SEL_MEM) begin
            state          <= MEM;
            ext_valid      <= 1'b1;
            ext_write      <= bus.mem_write;
            ext_strobe     <= bus.mem_strobe;
            ext_address    <= bus.mem_address;
            ext_write_data <= bus.mem_write_data;
            if (bus.fetch_request && (starve_count != LIMIT)) begin
              starve_count <= starve_count + 1'b1;
            end
          end else if (grant == SEL_FETCH) begin
            state          <= FETCH;
            ext_valid      <= 1'b1;
            ext_write      <= 1'b0;
            ext_strobe     <= '0;
            ext_address    <= bus.fetch_address;
            ext_write_data <= '0;
            starve_count   <= '0;
          end
        end
        FETCH: begin
          if (bus.ext_ready) begin
            state     <= IDLE;
            ext_valid <= 1'b0;
            // A redirected fetch drops the word; fetch is re-arbitrated from IDLE.
            if (fetch_current) begin
              fetch_data <= bus.ext_read_data;
              fetch_done <= 1'b1;
            end
          end
        end
        MEM: begin
          if (bus.ext_ready) begin
            state         <= IDLE;
            ext_valid     <= 1'b0;
            mem_read_data <= bus.ext_read_data;
            mem_done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ext_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ext_valid      = ext_valid;
  assign bus.ext_write      = ext_write;
  assign bus.ext_strobe     = ext_strobe;
  assign bus.ext_address    = ext_address;
  assign bus.ext_write_data = ext_write_data;
  assign bus.fetch_data     = fetch_data;
  assign bus.mem_read_data  = mem_read_data;
  assign bus.fetch_ready    = !bus.fetch_request || fetch_done;
  assign bus.mem_ready      = !bus.mem_request || mem_done;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table of single/dual accesses,
// plus sequences for starvation, stale fetch and mid-transaction reset.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          write;
    logic [SW-1:0] strobe;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit            f_req;
    bit            m_req;
    bit            m_write;
    logic [SW-1:0] strobe;
    logic [AW-1:0] f_addr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] wdata;
    int unsigned   waits;
    logic [DW-1:0] f_data;
    logic [DW-1:0] m_data;
  } vec_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned wait_states = 0;
  int          txn_seen = 0;
  vec_t        vecs[6];

  // External memory contents as seen by the bench.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic w, input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    txn_t t;
    t.write   = w;
    t.strobe  = s;
    t.address = a;
    t.wdata   = d;
    exp_q.push_back(t);
  endtask

  // External responder and scoreboard: answers after wait_states cycles,
  // checks that a held request is stable and that each transfer is expected.
  initial begin : ext_side
    int unsigned cnt;
    bit          busy;
    bit          hold;
    txn_t        held;
    txn_t        obs;
    txn_t        e;
    busy = 0;
    hold = 0;
    cnt  = 0;
    bus.ext_ready     = 1'b0;
    bus.ext_read_data = '0;
    forever begin
      @(negedge clk);
      obs.write   = bus.ext_write;
      obs.strobe  = bus.ext_strobe;
      obs.address = bus.ext_address;
      obs.wdata   = bus.ext_write_data;
      if (!bus.ext_valid || reset) begin
        busy = 0;
        hold = 0;
        bus.ext_ready = 1'b0;
      end else begin
        if (hold) begin
          check("ext_hold_write", obs.write, held.write);
          check("ext_hold_strobe", obs.strobe, held.strobe);
          check("ext_hold_address", obs.address, held.address);
          check("ext_hold_wdata", obs.wdata, held.wdata);
        end
        if (!busy) begin
          busy = 1;
          cnt  = wait_states;
        end
        if (cnt == 0) begin
          bus.ext_ready     = 1'b1;
          bus.ext_read_data = rd_model(bus.ext_address);
          busy = 0;
          hold = 0;
          txn_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ext_txn: got transfer to 0x%0h write=%0d expected none", obs.address, obs.write);
          end else begin
            e = exp_q.pop_front();
            check("ext_txn_write", obs.write, e.write);
            check("ext_txn_strobe", obs.strobe, e.strobe);
            check("ext_txn_address", obs.address, e.address);
            if (e.write) check("ext_txn_wdata", obs.wdata, e.wdata);
          end
        end else begin
          bus.ext_ready = 1'b0;
          cnt--;
          hold = 1;
          held = obs;
        end
      end
    end
  end

  task automatic drive_idle();
    bus.fetch_request  = 1'b0;
    bus.fetch_address  = '0;
    bus.mem_request    = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_strobe     = '0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
  endtask

  // Apply one table entry; each requester drops its request once served.
  task automatic run_vector(input vec_t v, input int idx);
    string tag;
    bit    fp;
    bit    mp;
    bit    dm;
    bit    df;
    tag = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    wait_states        = v.waits;
    bus.fetch_request  = v.f_req;
    bus.fetch_address  = v.f_addr;
    bus.mem_request    = v.m_req;
    bus.mem_write      = v.m_write;
    bus.mem_strobe     = v.strobe;
    bus.mem_address    = v.m_addr;
    bus.mem_write_data = v.wdata;
    if (v.m_req) push_txn(v.m_write, v.strobe, v.m_addr, v.wdata);
    if (v.f_req) push_txn(1'b0, '0, v.f_addr, '0);
    fp = v.f_req;
    mp = v.m_req;
    if (!fp && !mp) begin
      repeat (4) begin
        @(negedge clk);
        check({tag, "_idle_fetch_ready"}, bus.fetch_ready, 1);
        check({tag, "_idle_mem_ready"}, bus.mem_ready, 1);
        check({tag, "_idle_ext_valid"}, bus.ext_valid, 0);
      end
      return;
    end
    for (int c = 0; c < 80 && (fp || mp); c++) begin
      dm = 0;
      df = 0;
      @(negedge clk);
      if (c == 0) begin
        if (mp) check({tag, "_mem_stall"}, bus.mem_ready, 0);
        if (fp) check({tag, "_fetch_stall"}, bus.fetch_ready, 0);
      end
      if (mp && bus.mem_ready) begin
        check({tag, "_mem_data"}, bus.mem_read_data, v.m_data);
        check({tag, "_mem_latency"}, c, 2 + v.waits);
        if (fp) check({tag, "_fetch_waits_for_mem"}, bus.fetch_ready, 0);
        mp = 0;
        dm = 1;
      end else if (fp && bus.fetch_ready) begin
        check({tag, "_fetch_data"}, bus.fetch_data, v.f_data);
        check({tag, "_fetch_latency"}, c, v.m_req ? 5 + 2 * v.waits : 2 + v.waits);
        fp = 0;
        df = 1;
      end
      @(posedge clk); #1;
      if (dm) bus.mem_request = 1'b0;
      if (df) bus.fetch_request = 1'b0;
    end
    if (fp || mp) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending fetch=%0d mem=%0d expected none", tag, fp, mp);
      drive_idle();
    end
  endtask

  // Memory stage keeps issuing; fetch must win after LIMIT memory grants.
  task automatic starve_test();
    int m_served;
    bit f_served;
    bit pulse_prev;
    bit dm;
    bit df;
    m_served   = 0;
    f_served   = 0;
    pulse_prev = 0;
    @(posedge clk); #1;
    wait_states       = 0;
    bus.fetch_request = 1'b1;
    bus.fetch_address = 32'h80;
    bus.mem_request   = 1'b1;
    bus.mem_write     = 1'b0;
    bus.mem_strobe    = 4'hF;
    bus.mem_address   = 32'h1000;
    for (int i = 0; i < 4; i++) push_txn(1'b0, 4'hF, 32'h1000 + 4 * i, '0);
    push_txn(1'b0, '0, 32'h80, '0);
    push_txn(1'b0, 4'hF, 32'h1010, '0);
    for (int c = 0; c < 200 && (m_served < 5 || !f_served); c++) begin
      dm = 0;
      df = 0;
      @(negedge clk);
      if (pulse_prev) check("starve_mem_ready_one_cycle", bus.mem_ready, 0);
      pulse_prev = 0;
      if (bus.mem_request && bus.mem_ready) begin
        check("starve_mem_data", bus.mem_read_data, rd_model(32'h1000 + 4 * m_served));
        if (m_served < 4) check("starve_fetch_still_waiting", bus.fetch_ready, 0);
        m_served++;
        dm = 1;
        pulse_prev = (m_served < 5);
      end
      if (bus.fetch_request && bus.fetch_ready) begin
        check("starve_mem_grants_before_fetch", m_served, LIMIT);
        check("starve_fetch_data", bus.fetch_data, rd_model(32'h80));
        f_served = 1;
        df = 1;
      end
      @(posedge clk); #1;
      if (dm) begin
        if (m_served < 5) bus.mem_address = 32'h1000 + 4 * m_served;
        else bus.mem_request = 1'b0;
      end
      if (df) bus.fetch_request = 1'b0;
    end
    if (m_served < 5 || !f_served) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout: got mem=%0d fetch=%0d expected mem=5 fetch=1", m_served, f_served);
      drive_idle();
    end
  endtask

  // Fetch redirected while its transaction waits: old word dropped, new one fetched.
  task automatic stale_test();
    int base;
    bit got;
    got = 0;
    @(posedge clk); #1;
    wait_states       = 3;
    base              = txn_seen;
    bus.fetch_request = 1'b1;
    bus.fetch_address = 32'h40;
    push_txn(1'b0, '0, 32'h40, '0);
    push_txn(1'b0, '0, 32'h80, '0);
    for (int c = 0; c < 20 && !bus.ext_valid; c++) @(negedge clk);
    check("stale_ext_valid_seen", bus.ext_valid, 1);
    @(posedge clk); #1;
    bus.fetch_address = 32'h80;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        check("stale_transfers_before_ready", txn_seen - base, 2);
        check("stale_fetch_data", bus.fetch_data, rd_model(32'h80));
        got = 1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL stale_timeout: got no fetch_ready expected one");
    end
    @(posedge clk); #1;
    bus.fetch_request = 1'b0;
  endtask

  // Reset while a load is outstanding.
  task automatic reset_test();
    @(posedge clk); #1;
    wait_states     = 20;
    bus.mem_request = 1'b1;
    bus.mem_write   = 1'b0;
    bus.mem_strobe  = 4'hF;
    bus.mem_address = 32'h500;
    for (int c = 0; c < 20 && !bus.ext_valid; c++) @(negedge clk);
    check("rst_ext_valid_before", bus.ext_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    check("rst_ext_valid_after", bus.ext_valid, 0);
    check("rst_fetch_ready_after", bus.fetch_ready, 1);
    check("rst_mem_ready_after", bus.mem_ready, 1);
    check("rst_state_after", dut.state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vecs[0] = '{0, 1, 0, 4'hF, 32'h0,  32'h100, 32'h0,         1, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{1, 0, 0, 4'h0, 32'h40, 32'h0,   32'h0,         0, 32'h0040FFBF, 32'h0};
    vecs[2] = '{0, 1, 1, 4'h3, 32'h0,  32'h200, 32'h1234,      3, 32'h0,         32'h0200FDFF};
    vecs[3] = '{1, 1, 0, 4'hF, 32'h44, 32'h104, 32'h0,         0, 32'h0044FFBB, 32'h0104FEFB};
    vecs[4] = '{1, 1, 1, 4'hF, 32'h48, 32'h300, 32'hCAFEF00D, 2, 32'h0048FFB7, 32'h0300FCFF};
    vecs[5] = '{0, 0, 0, 4'h0, 32'h0,  32'h0,   32'h0,         0, 32'h0,         32'h0};

    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ext_valid", bus.ext_valid, 0);
    check("reset_ext_write", bus.ext_write, 0);
    check("reset_ext_strobe", bus.ext_strobe, 0);
    check("reset_ext_address", bus.ext_address, 0);
    check("reset_ext_write_data", bus.ext_write_data, 0);
    check("reset_fetch_data", bus.fetch_data, 0);
    check("reset_mem_read_data", bus.mem_read_data, 0);
    check("reset_fetch_ready", bus.fetch_ready, 1);
    check("reset_mem_ready", bus.mem_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);
    starve_test();
    stale_test();
    reset_test();
    run_vector(vecs[0], 6);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
